pc_branch_unit: RTL and testbench

- Holds the program counter for the 16-bit multi-cycle processor and applies the PC-update strobes from the control FSM (PCWrite, PCSrc, Branch, BranchType, IRWrite) to the ALU result.
- Latches the branch target computed in the BRANCH state, then evaluates the branch condition in BRANCH2 from the ALU subtract result.
- Keeps the pre-increment PC for link and target arithmetic, and exports branch status and statistics.
- Sits directly downstream of the control FSM and beside the ALU. It feeds the ALU source-A mux and the instruction-memory address mux.

---
 rtl/pc_branch_unit.sv | 79 +++++++
 tb/tb_pc_branch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Program counter and branch unit for the 16-bit multi-cycle processor.
// Applies the control FSM's PC strobes to the ALU result and resolves branches.
module pc_branch_unit #(
    parameter int                 WIDTH    = 16,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             PCWrite,
    input  logic             PCSrc,
    input  logic             Branch,
    input  logic [1:0]       BranchType,
    input  logic             IRWrite,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_old,
    output logic [WIDTH-1:0] branch_target,
    output logic             branch_taken,
    output logic             misaligned,
    output logic [15:0]      taken_count
);

    logic zero;
    logic lt;
    logic cond_true;
    logic take_branch;
    logic latch_target;
    logic load_alu;

    // Branch condition from the ALU subtract rs1 - rs2; overflow corrects the sign for signed compares.
    always_comb begin
        zero      = (alu_result == '0);
        lt        = alu_result[WIDTH-1] ^ alu_overflow;
        cond_true = 1'b0;
        case (BranchType)
            2'b00:   cond_true = zero;
            2'b01:   cond_true = !zero;
            2'b10:   cond_true = lt;
            default: cond_true = !lt;
        endcase
    end

    assign load_alu     = PCWrite && !PCSrc;
    assign take_branch  = PCWrite && PCSrc && Branch && cond_true;
    assign latch_target = Branch && !PCWrite && !PCSrc;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc            <= RESET_PC;
            pc_old        <= RESET_PC;
            branch_target <= '0;
            branch_taken  <= 1'b0;
            misaligned    <= 1'b0;
            taken_count   <= '0;
        end else begin
            branch_taken <= 1'b0;
            if (IRWrite) begin
                pc_old <= pc;
            end
            if (latch_target) begin
                branch_target <= alu_result;
            end
            if (load_alu) begin
                pc <= {alu_result[WIDTH-1:1], 1'b0};
                if (alu_result[0]) begin
                    misaligned <= 1'b1;
                end
            end else if (take_branch) begin
                pc           <= branch_target;
                branch_taken <= 1'b1;
                if (taken_count != 16'hFFFF) begin
                    taken_count <= taken_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed vector table, saturation run, and random
// stimulus compared against a spec-level reference model.
module tb_pc_branch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWrite;
    logic        PCSrc;
    logic        Branch;
    logic [1:0]  BranchType;
    logic        IRWrite;
    logic [15:0] alu_result;
    logic        alu_overflow;
    logic [15:0] pc;
    logic [15:0] pc_old;
    logic [15:0] branch_target;
    logic        branch_taken;
    logic        misaligned;
    logic [15:0] taken_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_pc, m_pc_old, m_tgt, m_taken, m_mis, m_cnt;

    typedef struct {
        bit       rst, pcw, pcs, br;
        bit [1:0] bt;
        bit       irw;
        bit [15:0] alu;
        bit       ovf;
        bit [15:0] e_pc, e_old, e_tgt;
        bit       e_tk, e_mis;
        bit [15:0] e_cnt;
    } vec_t;

    vec_t table_v[$];

    pc_branch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
        .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .PCSrc(PCSrc), .Branch(Branch),
        .BranchType(BranchType), .IRWrite(IRWrite), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .pc(pc), .pc_old(pc_old), .branch_target(branch_target),
        .branch_taken(branch_taken), .misaligned(misaligned), .taken_count(taken_count)
    );

    always #5 CLK = ~CLK;

    // Spec-level model: one call per rising edge, using the inputs about to be sampled.
    task automatic modelStep();
        int  val;
        bit  less, cond;
        if (Reset) begin
            m_pc = 0; m_pc_old = 0; m_tgt = 0; m_taken = 0; m_mis = 0; m_cnt = 0;
            return;
        end
        val  = int'(alu_result);
        less = ((val >= 32768) != alu_overflow);
        case (BranchType)
            2'd0: cond = (val == 0);
            2'd1: cond = (val != 0);
            2'd2: cond = less;
            default: cond = !less;
        endcase
        m_taken = 0;
        if (IRWrite) m_pc_old = m_pc;
        if (PCWrite && !PCSrc) begin
            m_pc = val - (val % 2);
            if (val % 2 == 1) m_mis = 1;
        end else if (PCWrite && PCSrc && Branch && cond) begin
            m_pc    = m_tgt;
            m_taken = 1;
            m_cnt   = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        end
        if (Branch && !PCWrite && !PCSrc) m_tgt = val;
    endtask

    task automatic applyStimulus(input bit rst, input bit pcw, input bit pcs, input bit br,
                                 input bit [1:0] bt, input bit irw, input bit [15:0] alu,
                                 input bit ovf);
        @(negedge CLK);
        Reset = rst; PCWrite = pcw; PCSrc = pcs; Branch = br; BranchType = bt;
        IRWrite = irw; alu_result = alu; alu_overflow = ovf;
        modelStep();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkField(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int e_pc, input int e_old, input int e_tgt,
                               input int e_tk, input int e_mis, input int e_cnt);
        checkField({tag, ".pc"}, int'(pc), e_pc);
        checkField({tag, ".pc_old"}, int'(pc_old), e_old);
        checkField({tag, ".branch_target"}, int'(branch_target), e_tgt);
        checkField({tag, ".branch_taken"}, int'(branch_taken), e_tk);
        checkField({tag, ".misaligned"}, int'(misaligned), e_mis);
        checkField({tag, ".taken_count"}, int'(taken_count), e_cnt);
    endtask

    function automatic vec_t mk(bit rst, bit pcw, bit pcs, bit br, bit [1:0] bt, bit irw,
                                bit [15:0] alu, bit ovf, bit [15:0] e_pc, bit [15:0] e_old,
                                bit [15:0] e_tgt, bit e_tk, bit e_mis, bit [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.pcw = pcw; v.pcs = pcs; v.br = br; v.bt = bt; v.irw = irw;
        v.alu = alu; v.ovf = ovf; v.e_pc = e_pc; v.e_old = e_old; v.e_tgt = e_tgt;
        v.e_tk = e_tk; v.e_mis = e_mis; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        Reset = 1'b1; PCWrite = 1'b0; PCSrc = 1'b0; Branch = 1'b0; BranchType = 2'b00;
        IRWrite = 1'b0; alu_result = '0; alu_overflow = 1'b0;

        //                rst pcw pcs br bt     irw alu       ovf  pc        old       tgt      tk mis cnt
        table_v.push_back(mk(1, 1, 0, 0, 2'd0, 0, 16'h1234, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0));
        table_v.push_back(mk(0, 1, 0, 0, 2'd0, 1, 16'h0002, 0, 16'h0002, 16'h0000, 16'h0000, 0, 0, 16'd0));
        table_v.push_back(mk(0, 0, 0, 1, 2'd0, 0, 16'h0040, 0, 16'h0002, 16'h0000, 16'h0040, 0, 0, 16'd0));
        table_v.push_back(mk(0, 1, 1, 1, 2'd0, 0, 16'h0000, 0, 16'h0040, 16'h0000, 16'h0040, 1, 0, 16'd1));
        table_v.push_back(mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 0, 16'h0040, 16'h0000, 16'h0040, 0, 0, 16'd1));
        table_v.push_back(mk(0, 1, 0, 0, 2'd0, 1, 16'h0042, 0, 16'h0042, 16'h0040, 16'h0040, 0, 0, 16'd1));
        table_v.push_back(mk(0, 0, 0, 1, 2'd0, 0, 16'h0080, 0, 16'h0042, 16'h0040, 16'h0080, 0, 0, 16'd1));
        table_v.push_back(mk(0, 1, 1, 1, 2'd2, 0, 16'h8000, 1, 16'h0042, 16'h0040, 16'h0080, 0, 0, 16'd1));
        table_v.push_back(mk(0, 1, 1, 1, 2'd2, 0, 16'h8000, 0, 16'h0080, 16'h0040, 16'h0080, 1, 0, 16'd2));
        table_v.push_back(mk(0, 1, 0, 0, 2'd0, 0, 16'h0105, 0, 16'h0104, 16'h0040, 16'h0080, 0, 1, 16'd2));
        table_v.push_back(mk(0, 1, 0, 0, 2'd0, 1, 16'h0106, 0, 16'h0106, 16'h0104, 16'h0080, 0, 1, 16'd2));
        table_v.push_back(mk(0, 0, 0, 1, 2'd0, 0, 16'h0AAA, 0, 16'h0106, 16'h0104, 16'h0AAA, 0, 1, 16'd2));
        table_v.push_back(mk(0, 1, 1, 0, 2'd0, 0, 16'h0000, 0, 16'h0106, 16'h0104, 16'h0AAA, 0, 1, 16'd2));
        table_v.push_back(mk(0, 1, 1, 1, 2'd1, 0, 16'h0000, 0, 16'h0106, 16'h0104, 16'h0AAA, 0, 1, 16'd2));
        table_v.push_back(mk(0, 1, 1, 1, 2'd3, 0, 16'h0005, 0, 16'h0AAA, 16'h0104, 16'h0AAA, 1, 1, 16'd3));
        table_v.push_back(mk(0, 1, 0, 0, 2'd0, 0, 16'h0000, 0, 16'h0000, 16'h0104, 16'h0AAA, 0, 1, 16'd3));
        table_v.push_back(mk(0, 0, 0, 1, 2'd0, 0, 16'h0060, 0, 16'h0000, 16'h0104, 16'h0060, 0, 1, 16'd3));
        table_v.push_back(mk(1, 1, 1, 1, 2'd0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0));
        table_v.push_back(mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0));
        table_v.push_back(mk(0, 1, 0, 0, 2'd0, 0, 16'hFFFE, 0, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 16'd0));
        table_v.push_back(mk(0, 1, 0, 0, 2'd0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0));

        foreach (table_v[i]) begin
            applyStimulus(table_v[i].rst, table_v[i].pcw, table_v[i].pcs, table_v[i].br,
                          table_v[i].bt, table_v[i].irw, table_v[i].alu, table_v[i].ovf);
            checkOutput($sformatf("row%0d", i), int'(table_v[i].e_pc), int'(table_v[i].e_old),
                        int'(table_v[i].e_tgt), int'(table_v[i].e_tk), int'(table_v[i].e_mis),
                        int'(table_v[i].e_cnt));
        end

        // Saturation: latch a target, then hold a taken beq for 65535 edges plus one more.
        applyStimulus(0, 0, 0, 1, 2'd0, 0, 16'h0010, 0);
        for (int n = 0; n < 65535; n++) begin
            applyStimulus(0, 1, 1, 1, 2'd0, 0, 16'h0000, 0);
        end
        checkOutput("sat_reach", 16'h0010, 0, 16'h0010, 1, 0, 16'hFFFF);
        applyStimulus(0, 1, 1, 1, 2'd0, 0, 16'h0000, 0);
        checkOutput("sat_hold", 16'h0010, 0, 16'h0010, 1, 0, 16'hFFFF);
        applyStimulus(0, 0, 0, 0, 2'd0, 0, 16'h0000, 0);
        checkOutput("pulse_end", 16'h0010, 0, 16'h0010, 0, 0, 16'hFFFF);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit [15:0] alu;
            alu = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom());
            applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom()), 1'($urandom()),
                          1'($urandom()), 2'($urandom()), 1'($urandom()), alu, 1'($urandom()));
            checkOutput($sformatf("rand%0d", n), m_pc, m_pc_old, m_tgt, m_taken, m_mis, m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
